// File: rtl/mem_bus_pkg.sv
// Shared bus definitions for the memory arbiter: command codes, arbiter
// state encoding and default address/data widths.
package mem_bus_pkg;
  localparam int MEM_AW = 9;
  localparam int MEM_DW = 16;

  localparam logic [1:0] MNONE  = 2'b00;
  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDATA  = 2'd2
  } arb_state_e;

  // 2'b11 is reserved on the request side and behaves like no request.
  function automatic logic cmd_valid(input logic [1:0] cmd);
    return (cmd == MREAD) || (cmd == MWRITE);
  endfunction
endpackage

// File: rtl/arb_rr_pick.sv
// Two-way winner select. Round-robin by default; define ARB_FIXED_PRIO_EN
// to make port 0 win every tie (port 1 may then starve).
module arb_rr_pick (
  input  logic [1:0] req,
  input  logic       last_winner,
  output logic       winner,
  output logic       any_req
);
  assign any_req = |req;

`ifdef ARB_FIXED_PRIO_EN
  logic unused_last_winner;
  assign unused_last_winner = last_winner;
  assign winner = ~req[0];
`else
  always_comb begin
    winner = req[1];
    if (&req) winner = ~last_winner;
  end
`endif
endmodule

// File: rtl/mem_arbiter.sv
// Serializes CPU (port 0) and DMA/loader (port 1) onto the shared RAM/IO bus.
// Tie policy selected by ARB_FIXED_PRIO_EN (see arb_rr_pick).
module mem_arbiter
  import mem_bus_pkg::*;
#(
  parameter int AW = MEM_AW,
  parameter int DW = MEM_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    req0_cmd,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_wdata,
  output logic          grant0,
  output logic          rvalid0,
  input  logic [1:0]    req1_cmd,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_wdata,
  output logic          grant1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  output logic [1:0]    mem_cmd,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);
  arb_state_e    state_q, state_d;
  logic [1:0]    mem_cmd_q, mem_cmd_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [1:0]    grant_q, grant_d;
  logic [1:0]    rvalid_q, rvalid_d;
  logic          last_winner_q, last_winner_d;
  logic          owner_q, owner_d;

  logic [1:0] req_vld;
  logic       pick, any_req;

  assign req_vld = {cmd_valid(req1_cmd), cmd_valid(req0_cmd)};

  arb_rr_pick u_pick (
    .req         (req_vld),
    .last_winner (last_winner_q),
    .winner      (pick),
    .any_req     (any_req)
  );

  always_comb begin
    state_d       = state_q;
    mem_cmd_d     = mem_cmd_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    rdata_d       = rdata_q;
    last_winner_d = last_winner_q;
    owner_d       = owner_q;
    grant_d       = 2'b00;
    rvalid_d      = 2'b00;
    case (state_q)
      IDLE: begin
        mem_cmd_d = MNONE;
        if (any_req) begin
          state_d       = ACCESS;
          owner_d       = pick;
          last_winner_d = pick;
          grant_d[pick] = 1'b1;
          mem_cmd_d     = pick ? req1_cmd   : req0_cmd;
          mem_addr_d    = pick ? req1_addr  : req0_addr;
          mem_wdata_d   = pick ? req1_wdata : req0_wdata;
        end
      end
      ACCESS: begin
        // Reads keep mem_cmd/mem_addr for one more cycle so the IO decode
        // still drives mem_rdata when it is captured.
        if (mem_cmd_q == MREAD) begin
          state_d = RDATA;
        end else begin
          state_d   = IDLE;
          mem_cmd_d = MNONE;
        end
      end
      RDATA: begin
        state_d           = IDLE;
        mem_cmd_d         = MNONE;
        rdata_d           = mem_rdata;
        rvalid_d[owner_q] = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      mem_cmd_q     <= MNONE;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      rdata_q       <= '0;
      grant_q       <= 2'b00;
      rvalid_q      <= 2'b00;
      last_winner_q <= 1'b1;
      owner_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      mem_cmd_q     <= mem_cmd_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      rdata_q       <= rdata_d;
      grant_q       <= grant_d;
      rvalid_q      <= rvalid_d;
      last_winner_q <= last_winner_d;
      owner_q       <= owner_d;
    end
  end

  assign grant0    = grant_q[0];
  assign grant1    = grant_q[1];
  assign rvalid0   = rvalid_q[0];
  assign rvalid1   = rvalid_q[1];
  assign rdata     = rdata_q;
  assign mem_cmd   = mem_cmd_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a transaction-level predictor pushes
// per-cycle expectations, a negedge monitor pops and compares them.
module tb_mem_arbiter;
  import mem_bus_pkg::*;

  logic        clk, reset;
  logic [1:0]  req0_cmd, req1_cmd;
  logic [8:0]  req0_addr, req1_addr;
  logic [15:0] req0_wdata, req1_wdata;
  logic        grant0, grant1, rvalid0, rvalid1, busy;
  logic [15:0] rdata, mem_wdata, mem_rdata;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;

  mem_arbiter #(.AW(9), .DW(16)) dut (
    .clk(clk), .reset(reset),
    .req0_cmd(req0_cmd), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .grant0(grant0), .rvalid0(rvalid0),
    .req1_cmd(req1_cmd), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .grant1(grant1), .rvalid1(rvalid1),
    .rdata(rdata), .mem_cmd(mem_cmd), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Bus environment: RAM, LED register at 0x100, switches at 0x140.
  logic [15:0] ram [256];
  logic [15:0] led;
  logic [9:0]  sw;
  assign mem_rdata = mem_addr[8] ? ((mem_addr == 9'h140) ? {8'h00, sw[7:0]} : 16'h0000)
                                 : ram[mem_addr[7:0]];
  always @(posedge clk) begin
    if (mem_cmd == MWRITE) begin
      if (!mem_addr[8]) ram[mem_addr[7:0]] <= mem_wdata;
      else if (mem_addr == 9'h100) led <= mem_wdata;
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  // Predictor: transaction-level model of the arbiter and of the bus contents.
  localparam int EV_GRANT  = 0;
  localparam int EV_HOLD   = 1;
  localparam int EV_RVALID = 2;
  typedef struct {
    int          cyc;
    int          kind;
    int          port;
    logic [1:0]  cmd;
    logic [8:0]  addr;
    logic [15:0] data;
  } ev_t;
  ev_t expq[$];

  int          cyc = 0;
  int          free_at = 0;
  int          rst_cyc = -1;
  logic        mlw = 1'b1;
  logic [15:0] shadow [256];
  logic [15:0] mled = 16'h0;

  always @(posedge clk) begin
    ev_t         e;
    logic        v0, v1;
    int          w;
    logic [1:0]  c;
    logic [8:0]  a;
    logic [15:0] d;
    cyc++;
    if (reset) begin
      mlw = 1'b1;
      free_at = cyc + 1;
      rst_cyc = cyc;
      while (expq.size() > 0 && expq[$].cyc >= cyc) void'(expq.pop_back());
    end else if (cyc >= free_at) begin
      v0 = (req0_cmd == MREAD) || (req0_cmd == MWRITE);
      v1 = (req1_cmd == MREAD) || (req1_cmd == MWRITE);
      if (v0 || v1) begin
`ifdef ARB_FIXED_PRIO_EN
        w = v0 ? 0 : 1;
`else
        if (v0 && v1) w = mlw ? 0 : 1;
        else          w = v1 ? 1 : 0;
`endif
        mlw = (w == 1);
        c = (w == 1) ? req1_cmd   : req0_cmd;
        a = (w == 1) ? req1_addr  : req0_addr;
        d = (w == 1) ? req1_wdata : req0_wdata;
        e.cyc = cyc; e.kind = EV_GRANT; e.port = w; e.cmd = c; e.addr = a; e.data = d;
        expq.push_back(e);
        if (c == MREAD) begin
          e.cyc = cyc + 1; e.kind = EV_HOLD;
          expq.push_back(e);
          e.cyc = cyc + 2; e.kind = EV_RVALID;
          if (!a[8])            e.data = shadow[a[7:0]];
          else if (a == 9'h140) e.data = {8'h00, sw[7:0]};
          else                  e.data = 16'h0000;
          expq.push_back(e);
          free_at = cyc + 3;
        end else begin
          if (!a[8])            shadow[a[7:0]] = d;
          else if (a == 9'h100) mled = d;
          free_at = cyc + 2;
        end
      end
    end
  end

  // Monitor: pops this cycle's expectations and compares every output.
  logic [15:0] rdata_exp = 16'h0;
  always @(negedge clk) begin
    ev_t         e;
    logic [1:0]  eg, erv, ecmd;
    logic [8:0]  eaddr;
    logic [15:0] ewd;
    logic        ebusy, ck_addr, ck_wd;
    if (cyc > 0) begin
      eg = 2'b00; erv = 2'b00; ecmd = MNONE; eaddr = '0; ewd = '0;
      ebusy = 1'b0; ck_addr = 1'b0; ck_wd = 1'b0;
      while (expq.size() > 0 && expq[0].cyc <= cyc) begin
        e = expq.pop_front();
        if (e.cyc < cyc) begin
          n_chk++; n_fail++;
          $display("FAIL missed_event kind=%0d actual_cycle=%0d required_cycle=%0d", e.kind, cyc, e.cyc);
        end else begin
          case (e.kind)
            EV_GRANT: begin
              eg[e.port] = 1'b1; ebusy = 1'b1; ecmd = e.cmd; eaddr = e.addr; ck_addr = 1'b1;
              if (e.cmd == MWRITE) begin ewd = e.data; ck_wd = 1'b1; end
            end
            EV_HOLD: begin
              ebusy = 1'b1; ecmd = MREAD; eaddr = e.addr; ck_addr = 1'b1;
            end
            default: begin
              erv[e.port] = 1'b1; rdata_exp = e.data;
            end
          endcase
        end
      end
      if (rst_cyc == cyc) begin
        rdata_exp = 16'h0; eaddr = '0; ewd = '0; ck_addr = 1'b1; ck_wd = 1'b1;
      end
      chk("grant0", grant0, eg[0]);
      chk("grant1", grant1, eg[1]);
      chk("rvalid0", rvalid0, erv[0]);
      chk("rvalid1", rvalid1, erv[1]);
      chk("busy", busy, ebusy);
      chk("mem_cmd", mem_cmd, ecmd);
      chk("rdata", rdata, rdata_exp);
      if (ck_addr) chk("mem_addr", mem_addr, eaddr);
      if (ck_wd)   chk("mem_wdata", mem_wdata, ewd);
    end
  end

  task automatic drive(input int p, input logic [1:0] c, input logic [8:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    if (p == 0) begin req0_cmd = c; req0_addr = a; req0_wdata = d; end
    else        begin req1_cmd = c; req1_addr = a; req1_wdata = d; end
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (((p == 0) ? grant0 : grant1) === 1'b1) return;
    end
    n_chk++; n_fail++;
    $display("FAIL grant_timeout port=%0d actual=no_grant required=grant", p);
  endtask

  task automatic idle(input int p, input int n);
    @(posedge clk); #1;
    if (p == 0) req0_cmd = MNONE;
    else        req1_cmd = MNONE;
    repeat (n) @(posedge clk);
  endtask

  task automatic rand_master(input int p, input int n);
    for (int i = 0; i < n; i++) begin
      int          r, g;
      logic [1:0]  c;
      logic [8:0]  a;
      logic [15:0] d;
      r = $urandom_range(0, 9);
      d = 16'($urandom);
      if (r < 4)       begin c = MWRITE; a = 9'($urandom_range(0, 15)); end
      else if (r < 8)  begin c = MREAD;  a = 9'($urandom_range(0, 15)); end
      else if (r == 8) begin c = MREAD;  a = 9'h140; end
      else             begin c = MWRITE; a = 9'h100; end
      drive(p, c, a, d);
      g = $urandom_range(0, 2);
      if (g > 0) idle(p, g - 1);
    end
    idle(p, 0);
  endtask

  initial begin
    int bad;
    for (int i = 0; i < 256; i++) begin ram[i] = 16'h0; shadow[i] = 16'h0; end
    led = 16'h0; sw = 10'h000;
    reset = 1'b1;
    req0_cmd = MNONE; req0_addr = '0; req0_wdata = '0;
    req1_cmd = MNONE; req1_addr = '0; req1_wdata = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (10) @(posedge clk);

    // Write then read back through the other port.
    drive(0, MWRITE, 9'h005, 16'hABCD); idle(0, 0);
    drive(1, MREAD, 9'h005, 16'h0);     idle(1, 2);

    // Switch read returns low byte only.
    sw = 10'h3A5;
    drive(1, MREAD, 9'h140, 16'h0); idle(1, 2);

    // Both ports hammering the LED register.
    fork
      begin repeat (6) drive(0, MWRITE, 9'h100, 16'h0011); idle(0, 0); end
      begin repeat (6) drive(1, MWRITE, 9'h100, 16'h0022); idle(1, 0); end
    join
    repeat (2) @(posedge clk);
    chk("led_after_contention", led, mled);

    // Reset lands during RDATA of a port 0 read: no rvalid, rdata cleared.
    drive(0, MREAD, 9'h005, 16'h0);
    @(posedge clk); #1 req0_cmd = MNONE; reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    fork
      begin drive(0, MREAD, 9'h005, 16'h0); idle(0, 0); end
      begin drive(1, MWRITE, 9'h007, 16'h1234); idle(1, 0); end
    join
    repeat (3) @(posedge clk);

    // Reserved command is never granted.
    #1 req0_cmd = 2'b11;
    repeat (10) @(posedge clk);
    #1 req0_cmd = MNONE;
    repeat (2) @(posedge clk);

    fork
      rand_master(0, 60);
      rand_master(1, 60);
    join
    repeat (6) @(posedge clk);

    bad = 0;
    for (int i = 0; i < 256; i++) if (ram[i] !== shadow[i]) bad++;
    chk("ram_contents_bad_words", bad, 0);
    chk("led_final", led, mled);
    chk("scoreboard_drained", expq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end
endmodule
